// File: rtl/cic_decim_ctrl_pkg.sv
// Shared types and helpers for the CIC decimation sequencer: state encoding,
// log2 field width and the constant clog2 used to size the counters.
package cic_decim_ctrl_pkg;

    localparam int CIC_LOG2_W = 5;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } cic_state_e;

    // Never returns less than 1 so the result can always size a vector.
    function automatic int cic_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cic_decim_ctrl_settle_counter.sv
// Saturating strobe counter with synchronous clear, enable and a terminal-count
// flag; paces the CIC settle interval and, optionally, the blanked-strobe statistic.
module cic_settle_counter #(
    parameter int             W     = 4,
    parameter logic [W-1:0]   LIMIT = '1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LIMIT);

endmodule

// File: rtl/cic_decim_ctrl.sv
// Decimation-change sequencer for a power-of-two CIC decimator: validates requests,
// resets the CIC, loads R and blanks output strobes until the pipeline has settled.
// Optional statistics outputs blank_cnt/reconfig_cnt are enabled by CIC_CTRL_STATS_EN.
module cic_decim_ctrl
    import cic_decim_ctrl_pkg::*;
#(
    parameter int STAGES       = 5,
    parameter int MAX_LOG2     = 11,
    parameter int DEFAULT_LOG2 = 0,
    parameter int SETTLE_EXTRA = 0,
    parameter int RESET_CYCLES = 2,
    parameter int MD           = 18
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cfg_valid,
    input  logic [CIC_LOG2_W-1:0] cfg_log2,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    output logic [MD-1:0]         decimation,
    output logic [CIC_LOG2_W-1:0] cur_log2,
    output logic                  cic_reset,
    input  logic                  in_strobe,
    output logic                  cic_in_strobe,
    input  logic                  cic_out_strobe,
    output logic                  out_strobe,
`ifdef CIC_CTRL_STATS_EN
    output logic [15:0]           blank_cnt,
    output logic [7:0]            reconfig_cnt,
`endif
    output logic                  busy
);

    localparam int SETTLE_N = STAGES + SETTLE_EXTRA;
    localparam int CNT_W    = cic_clog2(SETTLE_N + 1);
    localparam int RC_W     = cic_clog2(RESET_CYCLES);

    cic_state_e            state_q;
    logic [RC_W-1:0]       rst_cnt_q;
    logic [CIC_LOG2_W-1:0] cur_log2_q;
    logic [MD-1:0]         decimation_q;
    logic                  cfg_err_q;
    logic [CNT_W-1:0]      settle_cnt_unused;
    logic                  settle_tc;
    logic                  in_run;
    logic                  accept;
    logic                  reject;

    assign in_run = (state_q == ST_RUN);
    assign accept = in_run && cfg_valid && (cfg_log2 <= CIC_LOG2_W'(MAX_LOG2));
    assign reject = in_run && cfg_valid && (cfg_log2 >  CIC_LOG2_W'(MAX_LOG2));

    // Terminal count sits one below the settle length: the strobe that reaches it
    // is itself still blanked and hands over to RUN.
    cic_settle_counter #(
        .W     (CNT_W),
        .LIMIT (CNT_W'(SETTLE_N - 1))
    ) u_settle (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (state_q != ST_SETTLE),
        .en_i   (cic_out_strobe),
        .cnt_o  (settle_cnt_unused),
        .tc_o   (settle_tc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RST;
            rst_cnt_q    <= '0;
            cur_log2_q   <= CIC_LOG2_W'(DEFAULT_LOG2);
            decimation_q <= MD'(1) << DEFAULT_LOG2;
            cfg_err_q    <= 1'b0;
        end else begin
            cfg_err_q <= reject;
            case (state_q)
                ST_RST: begin
                    if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
                        state_q   <= ST_SETTLE;
                        rst_cnt_q <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cic_out_strobe && settle_tc) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        state_q      <= ST_RST;
                        rst_cnt_q    <= '0;
                        cur_log2_q   <= cfg_log2;
                        decimation_q <= MD'(1) << cfg_log2;
                    end
                end
                default: begin
                    state_q   <= ST_RST;
                    rst_cnt_q <= '0;
                end
            endcase
        end
    end

    // Strobe gating is decoded straight from the registered state: no added latency.
    assign cic_reset     = (state_q == ST_RST);
    assign cic_in_strobe = in_strobe && (state_q != ST_RST);
    assign out_strobe    = cic_out_strobe && in_run;
    assign cfg_ready     = in_run;
    assign busy          = !in_run;
    assign cfg_err       = cfg_err_q;
    assign decimation    = decimation_q;
    assign cur_log2      = cur_log2_q;

`ifdef CIC_CTRL_STATS_EN
    logic       blank_tc_unused;
    logic [7:0] reconfig_cnt_q;

    // Any CIC output strobe outside RUN is a suppressed one, RST included.
    cic_settle_counter #(
        .W     (16),
        .LIMIT (16'hFFFF)
    ) u_blank (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (1'b0),
        .en_i   (cic_out_strobe && !in_run),
        .cnt_o  (blank_cnt),
        .tc_o   (blank_tc_unused)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reconfig_cnt_q <= '0;
        end else if (accept) begin
            reconfig_cnt_q <= reconfig_cnt_q + 8'd1;
        end
    end

    assign reconfig_cnt = reconfig_cnt_q;
`endif

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl: directed vector table, hand sequences
// for held requests and mid-settle reset, then randomized traffic against a model.
`timescale 1ns/1ps
module tb_cic_decim_ctrl;

    localparam int STAGES       = 5;
    localparam int MAX_LOG2     = 11;
    localparam int DEFAULT_LOG2 = 0;
    localparam int SETTLE_EXTRA = 0;
    localparam int RESET_CYCLES = 2;
    localparam int MD           = 18;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [4:0]    cfg_log2 = '0;
    logic          in_strobe = 1'b0;
    logic          cic_out_strobe = 1'b0;
    logic          cfg_ready, cfg_err, cic_reset, cic_in_strobe, out_strobe, busy;
    logic [MD-1:0] decimation;
    logic [4:0]    cur_log2;
`ifdef CIC_CTRL_STATS_EN
    logic [15:0]   blank_cnt;
    logic [7:0]    reconfig_cnt;
`endif

    always #5 clock = ~clock;

    cic_decim_ctrl #(
        .STAGES(STAGES), .MAX_LOG2(MAX_LOG2), .DEFAULT_LOG2(DEFAULT_LOG2),
        .SETTLE_EXTRA(SETTLE_EXTRA), .RESET_CYCLES(RESET_CYCLES), .MD(MD)
    ) dut (
        .clock(clock), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_log2(cfg_log2),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .decimation(decimation), .cur_log2(cur_log2),
        .cic_reset(cic_reset), .in_strobe(in_strobe), .cic_in_strobe(cic_in_strobe),
        .cic_out_strobe(cic_out_strobe), .out_strobe(out_strobe),
`ifdef CIC_CTRL_STATS_EN
        .blank_cnt(blank_cnt), .reconfig_cnt(reconfig_cnt),
`endif
        .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: remaining reset cycles and remaining strobes to blank.
    int m_log2, m_rst_left, m_blank_left, m_blank, m_reconf;
    bit m_err;

    function automatic bit m_running();
        return (m_rst_left == 0) && (m_blank_left == 0);
    endfunction

    task automatic model_reset();
        m_log2       = DEFAULT_LOG2;
        m_rst_left   = RESET_CYCLES;
        m_blank_left = STAGES + SETTLE_EXTRA;
        m_err        = 1'b0;
        m_blank      = 0;
        m_reconf     = 0;
    endtask

    task automatic model_edge();
        bit run;
        bit err_n;
        run   = m_running();
        err_n = 1'b0;
        if (cic_out_strobe && !run && m_blank < 65535) m_blank++;
        if (run) begin
            if (cfg_valid) begin
                if (int'(cfg_log2) <= MAX_LOG2) begin
                    m_log2       = cfg_log2;
                    m_rst_left   = RESET_CYCLES;
                    m_blank_left = STAGES + SETTLE_EXTRA;
                    m_reconf     = (m_reconf + 1) % 256;
                end else begin
                    err_n = 1'b1;
                end
            end
        end else if (m_rst_left > 0) begin
            m_rst_left--;
        end else if (cic_out_strobe) begin
            m_blank_left--;
        end
        m_err = err_n;
    endtask

    task automatic check_model(input string tag);
        bit run;
        logic [MD-1:0] dec;
        run = m_running();
        dec = '0;
        dec[m_log2] = 1'b1;
        chk({tag, ".cic_reset"},     cic_reset,     m_rst_left > 0);
        chk({tag, ".cic_in_strobe"}, cic_in_strobe, in_strobe && (m_rst_left == 0));
        chk({tag, ".out_strobe"},    out_strobe,    cic_out_strobe && run);
        chk({tag, ".cfg_ready"},     cfg_ready,     run);
        chk({tag, ".busy"},          busy,          !run);
        chk({tag, ".cfg_err"},       cfg_err,       m_err);
        chk({tag, ".decimation"},    decimation,    dec);
        chk({tag, ".cur_log2"},      cur_log2,      m_log2);
`ifdef CIC_CTRL_STATS_EN
        chk({tag, ".blank_cnt"},     blank_cnt,     m_blank);
        chk({tag, ".reconfig_cnt"},  reconfig_cnt,  m_reconf);
`endif
    endtask

    task automatic step(input logic v, input logic [4:0] l, input logic ins, input logic co,
                        input string tag);
        @(negedge clock);
        cfg_valid = v; cfg_log2 = l; in_strobe = ins; cic_out_strobe = co;
        #1;
        check_model(tag);
        model_edge();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset_n = 1'b0; cfg_valid = 1'b0; in_strobe = 1'b0; cic_out_strobe = 1'b0;
        model_reset();
        #1;
        check_model(tag);
        @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    typedef struct {
        logic v; logic [4:0] l; logic ins; logic co;
        logic e_rst; logic e_cin; logic e_out; logic e_rdy; logic e_err;
        logic [MD-1:0] e_dec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [4:0] l, input logic ins, input logic co,
                       input logic rst, input logic cin, input logic out, input logic rdy,
                       input logic err, input logic [MD-1:0] dec);
        vec_t r;
        r.v = v; r.l = l; r.ins = ins; r.co = co;
        r.e_rst = rst; r.e_cin = cin; r.e_out = out; r.e_rdy = rdy; r.e_err = err; r.e_dec = dec;
        tbl.push_back(r);
    endtask

    initial begin
        int first8;
        logic [MD-1:0] saved_dec;

        // Reset release, five blanked strobes, reject of 12, accept of 6, resequence.
        //   v  l   in co   rst cin out rdy err dec
        add(0,  0, 1, 1,   1,  0,  0,  0,  0,  1);
        add(0,  0, 1, 1,   1,  0,  0,  0,  0,  1);
        add(0,  0, 1, 1,   0,  1,  0,  0,  0,  1);
        add(0,  0, 0, 0,   0,  0,  0,  0,  0,  1);
        add(0,  0, 0, 1,   0,  0,  0,  0,  0,  1);
        add(0,  0, 1, 1,   0,  1,  0,  0,  0,  1);
        add(0,  0, 0, 1,   0,  0,  0,  0,  0,  1);
        add(0,  0, 0, 1,   0,  0,  0,  0,  0,  1);
        add(0,  0, 1, 1,   0,  1,  1,  1,  0,  1);
        add(0,  0, 0, 0,   0,  0,  0,  1,  0,  1);
        add(1, 12, 0, 1,   0,  0,  1,  1,  0,  1);
        add(0,  0, 0, 0,   0,  0,  0,  1,  1,  1);
        add(0,  0, 1, 0,   0,  1,  0,  1,  0,  1);
        add(1,  6, 1, 1,   0,  1,  1,  1,  0,  1);
        add(0,  0, 1, 1,   1,  0,  0,  0,  0, 64);
        add(0,  0, 1, 1,   1,  0,  0,  0,  0, 64);
        add(0,  0, 1, 1,   0,  1,  0,  0,  0, 64);
        add(0,  0, 0, 1,   0,  0,  0,  0,  0, 64);
        add(0,  0, 0, 1,   0,  0,  0,  0,  0, 64);
        add(0,  0, 0, 1,   0,  0,  0,  0,  0, 64);
        add(0,  0, 1, 1,   0,  1,  0,  0,  0, 64);
        add(0,  0, 1, 1,   0,  1,  1,  1,  0, 64);

        do_reset("reset0");
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            cfg_valid = tbl[i].v; cfg_log2 = tbl[i].l;
            in_strobe = tbl[i].ins; cic_out_strobe = tbl[i].co;
            #1;
            chk($sformatf("tbl%0d.cic_reset", i),     cic_reset,     tbl[i].e_rst);
            chk($sformatf("tbl%0d.cic_in_strobe", i), cic_in_strobe, tbl[i].e_cin);
            chk($sformatf("tbl%0d.out_strobe", i),    out_strobe,    tbl[i].e_out);
            chk($sformatf("tbl%0d.cfg_ready", i),     cfg_ready,     tbl[i].e_rdy);
            chk($sformatf("tbl%0d.busy", i),          busy,          !tbl[i].e_rdy);
            chk($sformatf("tbl%0d.cfg_err", i),       cfg_err,       tbl[i].e_err);
            chk($sformatf("tbl%0d.decimation", i),    decimation,    tbl[i].e_dec);
            chk($sformatf("tbl%0d.cur_log2", i),      cur_log2,      $clog2(tbl[i].e_dec));
            model_edge();
        end

        // Request held through RST/SETTLE is only taken on the first RUN cycle.
        do_reset("reset1");
        first8 = -1;
        for (int i = 0; i < 18; i++) begin
            step(i <= 7, 5'd3, 1'($urandom_range(0, 1)), 1'b1, $sformatf("held%0d", i));
            if (first8 < 0 && decimation == 18'd8) first8 = i;
        end
        chk("held.first_dec8_cycle", first8, 8);
        chk("held.final_dec", decimation, 8);

        // Asynchronous reset in the middle of SETTLE after a change to log2=6.
        step(1'b1, 5'd6, 1'b0, 1'b0, "mid.acc");
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 1'b1, 1'b1, $sformatf("mid%0d", i));
        saved_dec = decimation;
        chk("mid.dec_before", saved_dec, 64);
        @(negedge clock);
        cic_out_strobe = 1'b1; in_strobe = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("mid.async_cic_reset", cic_reset, 1);
        chk("mid.async_out_strobe", out_strobe, 0);
        chk("mid.async_decimation", decimation, 1 << DEFAULT_LOG2);
        model_reset();
        do_reset("reset2");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset($sformatf("rreset%0d", i));
            end else begin
                step($urandom_range(0, 3) == 0, 5'($urandom_range(0, 14)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $sformatf("rnd%0d", i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
